// File: rtl/loop_ddr_pkg.sv
// rtl/loop_ddr_pkg.sv - shared types and constants for the DDR4 app-interface arbiter
//
// Purpose: arbiter FSM state type, MIG command encodings and DDR4 user data widths.
// Ports:   none (package).

package loop_ddr_pkg;

    typedef enum logic {
        S_ARB   = 1'b0,
        S_ISSUE = 1'b1
    } arb_state_t;

    localparam logic [2:0] DDR4_CMD_WRITE = 3'b000;
    localparam logic [2:0] DDR4_CMD_READ  = 3'b001;

    localparam int DDR4_DATA_W = 512;
    localparam int DDR4_MASK_W = 64;

endpackage

// File: rtl/loop_ddr_tag_fifo.sv
// rtl/loop_ddr_tag_fifo.sv - in-order FIFO of requester indices for outstanding reads
//
// Purpose: remembers which requester issued each read so returning data can be steered.
// Ports:   clk/rst     clock, synchronous active-high reset (empties the FIFO)
//          push/push_data  enqueue a requester index
//          pop         dequeue the head entry (ignored when empty)
//          full/empty  occupancy flags; head = oldest entry

module loop_ddr_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/loop_ddr_arb.sv
// rtl/loop_ddr_arb.sv - round-robin sharing of one DDR4 MIG app interface between requesters
//
// Purpose: grants one requester command at a time to the MIG, records read issuers in a
//          tag FIFO and steers returning read data back to the issuing requester.
// Ports:   c0_ddr4_ui_clk / c0_ddr4_ui_clk_sync_rst   MIG UI clock, sync active-high reset
//          req_*        per-requester command inputs (flattened), req_ready accept pulse
//          rsp_valid/rsp_data   one-hot read return to requesters
//          c0_ddr4_app_*        MIG user interface
//          tag_full, err_orphan, cmd_cnt   status

module loop_ddr_arb
    import loop_ddr_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int REQ_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TAG_DEPTH = 32,
    parameter int ADDR_W    = 31
) (
    input  logic                            c0_ddr4_ui_clk,
    input  logic                            c0_ddr4_ui_clk_sync_rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0]       req_addr,
    input  logic [NUM_REQ*DDR4_DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DDR4_DATA_W-1:0]          rsp_data,
    input  logic                            c0_init_calib_complete,
    output logic                            c0_ddr4_app_en,
    output logic                            c0_ddr4_app_wdf_wren,
    output logic                            c0_ddr4_app_wdf_end,
    output logic [2:0]                      c0_ddr4_app_cmd,
    output logic [ADDR_W-1:0]               c0_ddr4_app_addr,
    output logic [DDR4_DATA_W-1:0]          c0_ddr4_app_wdf_data,
    output logic [DDR4_MASK_W-1:0]          c0_ddr4_app_wdf_mask,
    input  logic                            c0_ddr4_app_rdy,
    input  logic                            c0_ddr4_app_wdf_rdy,
    input  logic                            c0_ddr4_app_rd_data_valid,
    input  logic [DDR4_DATA_W-1:0]          c0_ddr4_app_rd_data,
    output logic                            tag_full,
    output logic                            err_orphan,
    output logic [31:0]                     cmd_cnt
);

    arb_state_t               state, state_next;
    logic [REQ_ID_W-1:0]      rr_ptr;
    logic [REQ_ID_W-1:0]      win_idx;
    logic                     win_rd;
    logic [ADDR_W-1:0]        win_addr;
    logic [DDR4_DATA_W-1:0]   win_wdata;

    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       rot;
    logic [REQ_ID_W:0]        sum;
    logic [REQ_ID_W-1:0]      grant_idx;
    logic                     grant_found;
    logic                     accept;

    logic                     rd_valid_q;
    logic [DDR4_DATA_W-1:0]   rd_data_q;
    logic                     tag_empty;
    logic [REQ_ID_W-1:0]      tag_head;
    logic                     tag_pop;

    logic [ADDR_W-1:0]        addr_arr  [NUM_REQ];
    logic [DDR4_DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DDR4_DATA_W +: DDR4_DATA_W];
    end

    // Reads are held back while every tag is in use; writes never need a tag.
    assign eligible = req_valid & ~(req_cmd & {NUM_REQ{tag_full}})
                    & {NUM_REQ{c0_init_calib_complete}};

    // Rotate so bit 0 is rr_ptr, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot         = NUM_REQ'({eligible, eligible} >> rr_ptr);
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && rot[i]) begin
                grant_found = 1'b1;
                sum = {1'b0, rr_ptr} + (REQ_ID_W+1)'(i);
                if (sum >= (REQ_ID_W+1)'(NUM_REQ)) sum = sum - (REQ_ID_W+1)'(NUM_REQ);
                grant_idx = sum[REQ_ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_next           = state;
        accept               = 1'b0;
        req_ready            = '0;
        c0_ddr4_app_en       = 1'b0;
        c0_ddr4_app_wdf_wren = 1'b0;
        c0_ddr4_app_wdf_end  = 1'b0;
        c0_ddr4_app_cmd      = DDR4_CMD_WRITE;
        case (state)
            S_ARB: begin
                if (grant_found) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                c0_ddr4_app_en       = 1'b1;
                c0_ddr4_app_cmd      = win_rd ? DDR4_CMD_READ : DDR4_CMD_WRITE;
                c0_ddr4_app_wdf_wren = !win_rd;
                c0_ddr4_app_wdf_end  = !win_rd;
                // Held until taken: calibration loss does not abandon an issued command.
                if (c0_ddr4_app_rdy && (win_rd || c0_ddr4_app_wdf_rdy)) begin
                    accept     = 1'b1;
                    req_ready  = NUM_REQ'(1) << win_idx;
                    state_next = S_ARB;
                end
            end
            default: state_next = S_ARB;
        endcase
    end

    always_ff @(posedge c0_ddr4_ui_clk) begin
        if (c0_ddr4_ui_clk_sync_rst) begin
            state      <= S_ARB;
            rr_ptr     <= '0;
            win_idx    <= '0;
            win_rd     <= 1'b0;
            win_addr   <= '0;
            win_wdata  <= '0;
            cmd_cnt    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_orphan <= 1'b0;
        end else begin
            state      <= state_next;
            rd_valid_q <= c0_ddr4_app_rd_data_valid;
            rd_data_q  <= c0_ddr4_app_rd_data;
            if (state == S_ARB && grant_found) begin
                win_idx   <= grant_idx;
                win_rd    <= req_cmd[grant_idx];
                win_addr  <= addr_arr[grant_idx];
                win_wdata <= wdata_arr[grant_idx];
            end
            if (accept) begin
                rr_ptr  <= (win_idx == REQ_ID_W'(NUM_REQ-1)) ? '0 : win_idx + REQ_ID_W'(1);
                cmd_cnt <= cmd_cnt + 32'd1;
            end
            // Includes data for tags discarded by a reset; the flag is sticky until reset.
            if (rd_valid_q && tag_empty) err_orphan <= 1'b1;
        end
    end

    assign tag_pop              = rd_valid_q && !tag_empty;
    assign rsp_valid            = tag_pop ? (NUM_REQ'(1) << tag_head) : '0;
    assign rsp_data             = rd_data_q;
    assign c0_ddr4_app_addr     = win_addr;
    assign c0_ddr4_app_wdf_data = win_wdata;
    assign c0_ddr4_app_wdf_mask = '0;

    loop_ddr_tag_fifo #(
        .WIDTH (REQ_ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (c0_ddr4_ui_clk),
        .rst       (c0_ddr4_ui_clk_sync_rst),
        .push      (accept && win_rd),
        .push_data (win_idx),
        .pop       (tag_pop),
        .full      (tag_full),
        .empty     (tag_empty),
        .head      (tag_head)
    );

endmodule

// File: doc/loop_ddr_arb.md
Name: loop_ddr_arb

Overview:
- Shares the single DDR4 MIG user (app) interface between NUM_REQ requesters, e.g. the host-driven DDR4 test engine and a packet buffer port.
- Round-robin arbitration on commands; one command is issued at a time.
- An in-order tag FIFO records which requester issued each read, so returning read data is steered back to that requester.
- Sits between requester logic and the MIG core in the c0_ddr4_ui_clk domain.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
REQ_ID_W, $clog2(NUM_REQ) (min 1), requester index width
TAG_DEPTH, 32, maximum outstanding reads (power of 2)
ADDR_W, 31, DDR4 app address width

Ports:
c0_ddr4_ui_clk  in  1  clock (MIG UI clock)
c0_ddr4_ui_clk_sync_rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  request pending, one bit per requester
req_cmd  in  NUM_REQ  per requester: 0 = write, 1 = read
req_addr  in  NUM_REQ*ADDR_W  per-requester address, flattened
req_wdata  in  NUM_REQ*512  per-requester write data
req_ready  out  NUM_REQ  one-cycle pulse: request accepted by MIG
rsp_valid  out  NUM_REQ  one-hot read data valid
rsp_data  out  512  read data, shared by all requesters
c0_init_calib_complete  in  1  MIG calibration done
c0_ddr4_app_en / app_wdf_wren / app_wdf_end  out  1  MIG command/write strobes
c0_ddr4_app_cmd  out  3  {2'b0, read}
c0_ddr4_app_addr  out  ADDR_W  command address
c0_ddr4_app_wdf_data  out  512  write data
c0_ddr4_app_wdf_mask  out  64  tied 0
c0_ddr4_app_rdy / app_wdf_rdy  in  1  MIG ready signals
c0_ddr4_app_rd_data_valid  in  1  MIG read data valid
c0_ddr4_app_rd_data  in  512  MIG read data
tag_full  out  1  TAG_DEPTH reads outstanding
err_orphan  out  1  sticky: read data arrived with no tag pending
cmd_cnt  out  32  accepted-command counter, wraps

Behaviour:
- Reset values:
  - state = S_ARB, rr_ptr = 0.
  - All strobes, req_ready, rsp_valid, err_orphan = 0; cmd_cnt = 0.
  - Tag FIFO is empty.
- Requester rules:
  - A requester holds valid/cmd/addr/wdata stable until its req_ready pulse.
  - Dropping valid before acceptance is illegal (bench asserts this).
- S_ARB:
  - Eligible requester: req_valid[i] = 1, and tag FIFO not full if req_cmd[i] = 1.
  - Nothing is eligible while c0_init_calib_complete = 0.
  - Winner is the first eligible index searching upward from rr_ptr, with wrap.
  - The winner's cmd/addr/wdata and index are registered; next state is S_ISSUE.
- S_ISSUE:
  - Drive app_en = 1, app_cmd, app_addr, app_wdf_data from the registered copy.
  - For writes, also drive app_wdf_wren = 1 and app_wdf_end = 1.
  - Accept condition: app_rdy = 1 and (read, or wdf_rdy = 1).
  - On accept, in the same cycle:
    - req_ready[winner] = 1;
    - rr_ptr = winner + 1 (mod NUM_REQ);
    - cmd_cnt += 1;
    - if read, push the winner index to the tag FIFO;
    - next state is S_ARB.
  - S_ISSUE never abandons a command. Calibration loss mid-issue does not abort it.
- Throughput: at most one command every 2 cycles.
- Latency: request to app_en is 1 cycle after S_ARB samples it.
- Read return:
  - rd_data_valid and rd_data are registered once.
  - Next cycle: rsp_valid[head tag] = 1, rsp_data = registered data, and the tag FIFO pops.
  - Read-return latency from MIG is 1 cycle.
  - If rd_data_valid = 1 while the tag FIFO is empty: no rsp_valid, data dropped, err_orphan set. Only reset clears err_orphan.
- Tag FIFO boundary cases:
  - Simultaneous push and pop is legal at any occupancy, including full: occupancy is unchanged.
  - Reads are not granted while full; writes are still granted.
  - tag_full = occupancy == TAG_DEPTH.
- Reset mid-operation: everything returns to reset values and outstanding tags are discarded. Late MIG read data then raises err_orphan, which is intended and documented.
- Fixed outputs: app_wdf_mask = 0; app_hi_pri and app_correct_en_i are not driven here (tied 0 at the top level).

Decomposition:
- Package loop_ddr_pkg:
  - typedef arb_state_t {S_ARB, S_ISSUE};
  - constants DDR4_CMD_WRITE = 3'b000, DDR4_CMD_READ = 3'b001;
  - DDR4_DATA_W = 512, DDR4_MASK_W = 64.
- Sub-module loop_ddr_tag_fifo:
  - synchronous FIFO, width REQ_ID_W, depth TAG_DEPTH;
  - outputs full, empty, head;
  - accepts push and pop in the same cycle.

Test Plan:
- Single write, requester 0, addr 0x100, app_rdy = wdf_rdy = 1 → app_en and wdf_wren high one cycle with addr 0x100; req_ready[0] pulses; cmd_cnt = 1.
- Both requesters hold valid reads back-to-back → grants alternate 0,1,0,1; MIG returns 4 beats → rsp_valid sequence 01,10,01,10 with data matched.
- Write with app_rdy = 1 but wdf_rdy = 0 for 5 cycles → app_en held 6 cycles, req_ready pulses only on the 6th.
- 32 reads issued with no return data → tag_full = 1 and further reads stall while a write from requester 1 is still granted; one read return drops tag_full.
- rd_data_valid pulse with no outstanding read → err_orphan = 1, no rsp_valid; it stays set until reset.
- c0_init_calib_complete = 0 with both valid → no app_en; calibration rises → first grant to requester 0 two cycles later.
